// File: rtl/risco5_uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and bit-timing helpers
// used by both the receiver and the transmitter.
package risco5_uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Clock cycles per serial bit (integer division).
    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned bit_rate);
        return clock_freq / bit_rate;
    endfunction

    // Cycles from the start-bit edge to the middle of the start bit.
    function automatic int unsigned half_bit(input int unsigned clock_freq,
                                             input int unsigned bit_rate);
        return clks_per_bit(clock_freq, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, reset_n (async, active low); push/wr_data write side;
// pop/rd_data read side (rd_data is the head entry while not empty);
// empty/full/count are registered status.
module uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push_c, do_pop_c;

    // A pop in the same cycle frees a slot, so a push is allowed even when full.
    always_comb begin
        do_pop_c  = pop & ~empty_q;
        do_push_c = push & (~full_q | do_pop_c);
        wr_ptr_d  = wr_ptr_q + AW'(do_push_c);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop_c);
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_d = count_q - CW'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a FWFT byte FIFO.
// Ports: clk, reset_n (async, active low); rx serial input (async, idle high);
// rd_en pops the head byte shown on rd_data; empty/full/count FIFO status;
// frame_error/overflow sticky flags cleared by a clear_errors pulse.
module uart_rx_buffered
    import risco5_uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 100_000_000,
    parameter int unsigned BIT_RATE    = 115_200,
    parameter int unsigned BUFFER_SIZE = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           rx,
    input  logic                           rd_en,
    output logic [7:0]                     rd_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(BUFFER_SIZE):0]   count,
    output logic                           frame_error,
    output logic                           overflow,
    input  logic                           clear_errors
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BIT_RATE);
    localparam int unsigned HALF_BIT     = half_bit(CLOCK_FREQ, BIT_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

    rx_state_e                state_q, state_d;
    logic                     rx_meta_q, rx_meta_d;
    logic                     rx_sync_q, rx_sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic                     frame_error_q, frame_error_d;
    logic                     overflow_q, overflow_d;
    logic                     half_done_c, bit_done_c;
    logic                     push_c, set_fe_c, set_ov_c;

    assign half_done_c = (cnt_q == CNT_W'(HALF_BIT - 1));
    assign bit_done_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:      if (!rx_sync_q) state_d = RX_START;
            RX_START:     if (half_done_c) state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:      if (bit_done_c && bit_idx_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
            RX_STOP:      if (bit_done_c) state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync_q) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // Datapath and event outputs of the FSM.
    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_c    = 1'b0;
        set_fe_c  = 1'b0;
        set_ov_c  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            RX_START: begin
                if (half_done_c) cnt_d = '0;
            end
            RX_DATA: begin
                if (bit_done_c) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (bit_done_c) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        set_fe_c = 1'b1;
                    end else if (full) begin
                        set_ov_c = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
        // A set event outranks a simultaneous clear.
        frame_error_d = set_fe_c | (frame_error_q & ~clear_errors);
        overflow_d    = set_ov_c | (overflow_q & ~clear_errors);
    end

    // Synchronizer, bit timing, shift register and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end

    uart_fifo #(
        .DEPTH (BUFFER_SIZE),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .wr_data (shift_q),
        .pop     (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered with a reduced bit period (17 clocks per bit)
// so every scenario fits in a short run. Expected FIFO contents and flags
// come from a frame-level model: a queue of bytes plus two sticky bits.
module tb_uart_rx_buffered;
    localparam int unsigned CLOCK_FREQ = 1_000_000;
    localparam int unsigned BIT_RATE   = 58_000;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned C          = CLOCK_FREQ / BIT_RATE;
    localparam int unsigned H          = C / 2;
    localparam int unsigned LAT        = 2 + H + 9 * C + 1;
    localparam int unsigned CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          clear_errors = 1'b0;
    logic [7:0]    rd_data;
    logic          empty, full, frame_error, overflow;
    logic [CW-1:0] count;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [7:0]    exp_q[$];
    bit            fe_exp = 1'b0;
    bit            ov_exp = 1'b0;
    int            lat_k;
    int            burst_got;
    int            burst_budget;
    logic [7:0]    b;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLOCK_FREQ  (CLOCK_FREQ),
        .BIT_RATE    (BIT_RATE),
        .BUFFER_SIZE (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .frame_error  (frame_error),
        .overflow     (overflow),
        .clear_errors (clear_errors)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: what a completed frame does to the FIFO and flags.
    task automatic model_frame(input logic [7:0] data, input bit stop_ok);
        if (!stop_ok) fe_exp = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(data);
        else ov_exp = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame starting at a falling clock edge; a bad stop bit
    // can be stretched into a break of extra bit times.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int break_bits);
        model_frame(data, stop_ok);
        rx = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            idle(C);
        end
        rx = stop_ok;
        idle(C * (1 + (stop_ok ? 0 : break_bits)));
        rx = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
        check({tag, "_fe"},    32'(frame_error), 32'(fe_exp));
        check({tag, "_ov"},    32'(overflow), 32'(ov_exp));
    endtask

    // Back-to-back pops, checking each head byte against the model.
    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_nonempty"}, 32'(empty), 32'd0);
            if (exp_q.size() > 0) check({tag, "_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
            rd_en = 1'b1;
            idle(1);
        end
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clear_errors = 1'b1;
        idle(1);
        clear_errors = 1'b0;
        fe_exp = 1'b0;
        ov_exp = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        idle(3);
        check_state("reset");
        reset_n = 1'b1;
        idle(5);

        // Single byte with latency window.
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                lat_k = 0;
                while (empty && lat_k < int'(LAT) + 50) begin
                    @(negedge clk);
                    lat_k++;
                end
            end
        join
        check("latency", (lat_k >= int'(LAT) - 1 && lat_k <= int'(LAT) + 1) ? LAT : 32'(lat_k), LAT);
        idle(3);
        check_state("single");
        drain("single", 1);
        check_state("single_read");

        // Burst 0x00..0x13 with a continuous reader (wraps the pointers).
        burst_got = 0;
        burst_budget = 20 * 12 * int'(C) + 400;
        fork
            for (int i = 0; i < 20; i++) send_frame(8'(i), 1'b1, 0);
            begin
                while (burst_got < 20 && burst_budget > 0) begin
                    @(negedge clk);
                    burst_budget--;
                    if (!empty) begin
                        if (exp_q.size() == 0) check("burst_unexpected", 32'(rd_data), 32'hFFFF);
                        else check("burst_data", 32'(rd_data), 32'(exp_q.pop_front()));
                        rd_en = 1'b1;
                        burst_got++;
                    end else begin
                        rd_en = 1'b0;
                    end
                end
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        check("burst_count", 32'(burst_got), 32'd20);
        idle(3);
        check_state("burst");

        // Overflow: 16 random bytes fill the FIFO, the 17th is dropped.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 0);
            idle($urandom_range(1, 6));
        end
        check_state("ovf16");
        send_frame(8'($urandom), 1'b1, 0);
        idle(3);
        check_state("ovf17");
        check("ovf_head", 32'(rd_data), 32'(exp_q[0]));
        clear_flags();
        check_state("ovf_clear");
        drain("ovf", 16);
        check_state("ovf_drained");

        // Framing error followed by a 3-bit break, then a good byte.
        send_frame(8'h3C, 1'b0, 3);
        idle(5);
        check_state("frame_bad");
        send_frame(8'h7E, 1'b1, 0);
        idle(3);
        check_state("frame_good");
        drain("frame", 1);
        clear_flags();
        check_state("frame_clear");

        // Short low glitches shorter than half a bit produce nothing.
        for (int g = 0; g < 4; g++) begin
            rx = 1'b0;
            idle($urandom_range(1, H - 2));
            rx = 1'b1;
            idle(2 * C);
        end
        check_state("glitch");
        b = 8'($urandom);
        send_frame(b, 1'b1, 0);
        idle(3);
        check_state("glitch_after");
        drain("glitch", 1);

        // Random mix of good and bad frames with random gaps.
        for (int i = 0; i < 12; i++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
            idle($urandom_range(3, 8));
        end
        check_state("rand");
        drain("rand", exp_q.size());
        clear_flags();
        check_state("rand_clear");

        // Async reset in the middle of a frame with data and a flag pending.
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b0, 0);
        idle(4);
        send_frame(8'h33, 1'b1, 0);
        idle(3);
        check_state("prereset");
        fork
            send_frame(8'h5A, 1'b1, 0);
            begin
                idle(H + 3 * C);
                #2 reset_n = 1'b0;
                #1;
                check("arst_empty", 32'(empty), 32'd1);
                check("arst_full",  32'(full), 32'd0);
                check("arst_count", 32'(count), 32'd0);
                check("arst_fe",    32'(frame_error), 32'd0);
                check("arst_ov",    32'(overflow), 32'd0);
            end
        join
        exp_q.delete();
        fe_exp = 1'b0;
        ov_exp = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(5);
        check_state("post_reset");
        b = 8'($urandom);
        send_frame(b, 1'b1, 0);
        idle(3);
        check_state("post_reset_rx");
        drain("post_reset", 1);
        check_state("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
